fetch_buffer: RTL and testbench



---
 rtl/fetch_buffer_if.sv | 36 +++
 rtl/fetch_buffer.sv | 153 +++++++++++++++
 tb/tb_fetch_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bus: decode control, instruction-memory request/response, decode output.
// Latency: none; this is a signal bundle.
// Backpressure: imem_req_ready throttles requests; stall holds the decode-side head entry.
//
// Ports/signals:
//   stall, redirect, redirect_pc              pipeline control into the fetch buffer
//   imem_req_valid/addr, imem_req_ready       fetch request channel (valid/ready)
//   imem_rsp_valid/data                       in-order fetch responses
//   out_valid, out_pc, out_instr              head entry presented to decode
// Modports: master = fetch buffer side, slave = pipeline/memory side.
interface fetch_buffer_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic             imem_req_valid;
  logic [PC_W-1:0]  imem_req_addr;
  logic             imem_req_ready;
  logic             imem_rsp_valid;
  logic [INS_W-1:0] imem_rsp_data;
  logic             out_valid;
  logic [PC_W-1:0]  out_pc;
  logic [INS_W-1:0] out_instr;

  modport master (
    input  stall, redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr
  );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction-fetch buffer: issues sequential fetch PCs, holds up to DEPTH PC/instruction pairs, presents the oldest to decode.
// Latency: request accepted in cycle N, response in N+1 earliest, out_valid in N+2.
// Backpressure: requests stop when allocated slots plus responses still to be dropped reach DEPTH; stall holds the head.
//
// Ports:
//   clk, reset (asynchronous, active low)
//   bus : fetch_buffer_if.master (control, imem request/response, decode output)
// Optional build macro FETCH_BUF_PERF_EN adds perf_fetched / perf_dropped (32-bit wrapping counters).
module fetch_buffer #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  fetch_buffer_if.master bus
`ifdef FETCH_BUF_PERF_EN
  ,
  output logic [31:0]    perf_fetched,
  output logic [31:0]    perf_dropped
`endif
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra bit so full and empty are distinguishable.
  localparam int CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  // run holds requests off until the first edge after reset release.
  logic             run;
  logic [PC_W-1:0]  fetch_pc;
  logic [CW-1:0]    head;
  logic [CW-1:0]    tail;
  logic [CW-1:0]    fill;
  logic [CW-1:0]    drop_cnt;
  logic [PC_W-1:0]  slot_pc    [DEPTH];
  logic [INS_W-1:0] slot_instr [DEPTH];
  logic [DEPTH-1:0] slot_filled;

  logic [AW-1:0]    head_idx;
  logic [AW-1:0]    tail_idx;
  logic [AW-1:0]    fill_idx;
  logic [CW-1:0]    count;
  logic [CW-1:0]    pending;
  logic [CW-1:0]    outstanding;
  logic [CW-1:0]    drop_next;
  logic [CW:0]      credit_used;
  logic             accept;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             consume;

  assign head_idx = head[AW-1:0];
  assign tail_idx = tail[AW-1:0];
  assign fill_idx = fill[AW-1:0];

  // count: allocated slots; pending: allocated but not yet filled.
  assign count       = tail - head;
  assign pending     = tail - fill;
  assign outstanding = pending + drop_cnt;
  assign credit_used = {1'b0, count} + {1'b0, drop_cnt};

  assign bus.imem_req_valid = run & ~bus.redirect & (credit_used < CREDITS);
  assign bus.imem_req_addr  = fetch_pc;
  assign accept             = bus.imem_req_valid & bus.imem_req_ready;

  // Stale responses are retired first; a response with nothing outstanding is ignored.
  assign rsp_drop = bus.imem_rsp_valid & (drop_cnt != '0);
  assign rsp_fill = bus.imem_rsp_valid & (drop_cnt == '0) & (pending != '0);

  // On redirect every outstanding request becomes stale, except that one arriving
  // in the redirect cycle itself is discarded right away.
  assign drop_next = (bus.imem_rsp_valid && (outstanding != '0)) ? outstanding - CW'(1)
                                                                 : outstanding;

  assign bus.out_valid = slot_filled[head_idx];
  assign bus.out_pc    = slot_pc[head_idx];
  assign bus.out_instr = slot_filled[head_idx] ? slot_instr[head_idx] : '0;

  assign consume = bus.out_valid & ~bus.stall & ~bus.redirect;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run         <= 1'b0;
      fetch_pc    <= '0;
      head        <= '0;
      tail        <= '0;
      fill        <= '0;
      drop_cnt    <= '0;
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]    <= '0;
        slot_instr[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (bus.redirect) begin
        fetch_pc    <= bus.redirect_pc;
        head        <= '0;
        tail        <= '0;
        fill        <= '0;
        drop_cnt    <= drop_next;
        slot_filled <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          slot_pc[i] <= '0;
        end
      end else begin
        // Accept, fill and consume never touch the same slot: accept needs a free
        // slot, fill targets an unfilled one, consume targets the filled head.
        if (accept) begin
          slot_pc[tail_idx]     <= fetch_pc;
          slot_filled[tail_idx] <= 1'b0;
          tail                  <= tail + CW'(1);
          fetch_pc              <= fetch_pc + PC_W'(4);
        end
        if (rsp_drop) begin
          drop_cnt <= drop_cnt - CW'(1);
        end else if (rsp_fill) begin
          slot_instr[fill_idx]  <= bus.imem_rsp_data;
          slot_filled[fill_idx] <= 1'b1;
          fill                  <= fill + CW'(1);
        end
        if (consume) begin
          slot_filled[head_idx] <= 1'b0;
          head                  <= head + CW'(1);
        end
      end
    end
  end

`ifdef FETCH_BUF_PERF_EN
  logic          rsp_discard;
  logic [CW-1:0] filled_cnt;

  // Filled entries always sit contiguously from head up to fill.
  assign filled_cnt  = fill - head;
  assign rsp_discard = bus.imem_rsp_valid & ((drop_cnt != '0) | (bus.redirect & (outstanding != '0)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      if (consume) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      perf_dropped <= perf_dropped + 32'(rsp_discard)
                    + (bus.redirect ? 32'(filled_cnt) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with an in-order fixed-latency memory model and a PC/instruction scoreboard.
// Latency: memory answers a fixed number of cycles after each accepted request.
// Backpressure: the bench drives stall, redirect and imem_req_ready per step.
module tb_fetch_buffer;
  localparam int PC_W  = 9;
  localparam int INS_W = 32;
  localparam int DEPTH = 4;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_buffer_if #(.PC_W(PC_W), .INS_W(INS_W)) bif ();

`ifdef FETCH_BUF_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  fetch_buffer #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bif)
`ifdef FETCH_BUF_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_dropped (perf_dropped)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc;
  int lat;
  int n_accept;

  logic [PC_W-1:0]  model_pc;
  logic [PC_W-1:0]  mem_addr_q [$];
  int               mem_due_q  [$];
  logic [PC_W-1:0]  exp_pc_q   [$];
  logic [INS_W-1:0] exp_ins_q  [$];
  logic [PC_W-1:0]  cons_log   [$];
  logic [PC_W-1:0]  acc_log    [$];

  function automatic logic [INS_W-1:0] data_of(input logic [PC_W-1:0] a);
    return 32'h0000_A000 | INS_W'(a);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, let logic settle, then
  // score consumption and requests against the model.
  task automatic step(input bit st, input bit rd, input logic [PC_W-1:0] rpc, input bit rdy);
    logic [PC_W-1:0] a;
    @(negedge clk);
    bif.stall          = st;
    bif.redirect       = rd;
    bif.redirect_pc    = rpc;
    bif.imem_req_ready = rdy;
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      bif.imem_rsp_valid = 1'b1;
      bif.imem_rsp_data  = data_of(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      bif.imem_rsp_valid = 1'b0;
      bif.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    if (!bif.out_valid) check("bubble_instr", bif.out_instr, 0);
    if (bif.out_valid && !st && !rd) begin
      cons_log.push_back(bif.out_pc);
      check("sb_nonempty", 32'(exp_pc_q.size() != 0), 1);
      if (exp_pc_q.size() != 0) begin
        check("sb_out_pc", bif.out_pc, exp_pc_q.pop_front());
        check("sb_out_instr", bif.out_instr, exp_ins_q.pop_front());
      end
    end
    if (rd) check("redirect_req_vld", bif.imem_req_valid, 0);
    if (bif.imem_req_valid && rdy) begin
      a = bif.imem_req_addr;
      check("req_addr", a, model_pc);
      acc_log.push_back(a);
      mem_addr_q.push_back(a);
      mem_due_q.push_back(cyc + lat);
      exp_pc_q.push_back(model_pc);
      exp_ins_q.push_back(data_of(model_pc));
      model_pc = model_pc + PC_W'(4);
      n_accept++;
    end
    if (rd) begin
      exp_pc_q.delete();
      exp_ins_q.delete();
      cons_log.delete();
      model_pc = rpc;
    end
    cyc++;
  endtask

  task automatic reset_dut(input int l);
    @(negedge clk);
    reset              = 1'b0;
    bif.stall          = 1'b0;
    bif.redirect       = 1'b0;
    bif.redirect_pc    = '0;
    bif.imem_req_ready = 1'b1;
    bif.imem_rsp_valid = 1'b0;
    bif.imem_rsp_data  = '0;
    #1;
    check("rst_req_vld", bif.imem_req_valid, 0);
    check("rst_req_addr", bif.imem_req_addr, 0);
    check("rst_out_vld", bif.out_valid, 0);
    check("rst_out_pc", bif.out_pc, 0);
    check("rst_out_instr", bif.out_instr, 0);
    lat      = l;
    model_pc = '0;
    n_accept = 0;
    mem_addr_q.delete();
    mem_due_q.delete();
    exp_pc_q.delete();
    exp_ins_q.delete();
    cons_log.delete();
    acc_log.delete();
    @(negedge clk);
    reset = 1'b1;
    cyc   = 1;
  endtask

  initial begin
    reset              = 1'b0;
    bif.stall          = 1'b0;
    bif.redirect       = 1'b0;
    bif.redirect_pc    = '0;
    bif.imem_req_ready = 1'b0;
    bif.imem_rsp_valid = 1'b0;
    bif.imem_rsp_data  = '0;

    // Streaming with a latency-1 memory.
    reset_dut(1);
    step(0, 0, 0, 1);
    check("t1_c1_req_vld", bif.imem_req_valid, 1);
    check("t1_c1_out_vld", bif.out_valid, 0);
    step(0, 0, 0, 1);
    check("t1_c2_out_vld", bif.out_valid, 0);
    step(0, 0, 0, 1);
    check("t1_c3_out_vld", bif.out_valid, 1);
    check("t1_c3_out_pc", bif.out_pc, 0);
    check("t1_c3_out_instr", bif.out_instr, 32'h0000_A000);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 1);
      check("t1_stream_vld", bif.out_valid, 1);
    end
    check("t1_consumed", cons_log.size(), 9);

    // Stall held: buffer fills to DEPTH, then drains in order.
    reset_dut(1);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 1);
      check("t2_head_pc_held", bif.out_pc, 0);
    end
    check("t2_accepts", n_accept, 4);
    check("t2_full_req_vld", bif.imem_req_valid, 0);
    check("t2_full_out_vld", bif.out_valid, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    check("t2_drained", cons_log.size(), 8);
    for (int i = 0; i < 4; i++) check("t2_order", cons_log[i], 32'(i * 4));
    check("t2_resume_addr", acc_log[4], 32'h010);

    // Redirect with three requests in flight on a latency-3 memory.
    reset_dut(3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    check("t3_in_flight", mem_addr_q.size(), 3);
    step(0, 1, 9'h040, 1);
    step(0, 0, 0, 1);
    check("t3_req_addr", bif.imem_req_addr, 32'h040);
    check("t3_req_vld", bif.imem_req_valid, 1);
    check("t3_out_vld", bif.out_valid, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    check("t3_got_output", 32'(cons_log.size() != 0), 1);
    if (cons_log.size() != 0) check("t3_first_pc", cons_log[0], 32'h040);

    // Redirect together with stall while the head is valid.
    reset_dut(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    step(1, 1, 9'h100, 1);
    check("t4_pre_out_vld", bif.out_valid, 1);
    step(0, 0, 0, 1);
    check("t4_out_vld", bif.out_valid, 0);
    check("t4_req_addr", bif.imem_req_addr, 32'h100);
    check("t4_req_vld", bif.imem_req_valid, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    check("t4_got_output", 32'(cons_log.size() != 0), 1);
    if (cons_log.size() != 0) check("t4_first_pc", cons_log[0], 32'h100);

    // PC wrap from 0x1FC to 0x000.
    step(0, 1, 9'h1FC, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    check("t5_got_two", 32'(cons_log.size() >= 2), 1);
    if (cons_log.size() >= 2) begin
      check("t5_pc0", cons_log[0], 32'h1FC);
      check("t5_pc1", cons_log[1], 32'h000);
    end

    // Memory not ready: address held, nothing allocated.
    step(0, 1, 9'h080, 1);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      check("t6_req_vld", bif.imem_req_valid, 1);
      check("t6_addr_hold", bif.imem_req_addr, 32'h080);
      check("t6_out_vld", bif.out_valid, 0);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    check("t6_got_output", 32'(cons_log.size() != 0), 1);
    if (cons_log.size() != 0) check("t6_first_pc", cons_log[0], 32'h080);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
